// File: rtl/round_pipe.sv
// Two-stage valid/ready pipeline that rounds signed fixed point (FW fraction bits) to an OW-bit integer.
// Define ROUND_PIPE_SAT_EN to saturate on overflow; otherwise the result wraps and out_sat is tied low.
module round_pipe #(
    parameter int DW = 16,
    parameter int FW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [1:0]          in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-FW-1:0]    out_data,
    output logic                out_inexact,
    output logic                out_sat
);
    localparam int unsigned OW = DW - FW;
    localparam logic [OW-1:0] INT_MAX = {1'b0, {(OW-1){1'b1}}};

    logic [OW-1:0] in_int;
    logic          in_half;
    logic          in_tail;
    logic          in_sign;
    logic          in_up;
    logic          in_fire;

    logic          s1_valid;
    logic [OW-1:0] s1_int;
    logic          s1_up;
    logic          s1_inexact;
    logic          s1_adv;
    logic          s2_load;

    logic [OW-1:0] res_data;

    // Field split and per-mode round-up decision on the incoming beat.
    always_comb begin
        in_int  = in_data[DW-1:FW];
        in_half = in_data[FW-1];
        in_tail = |in_data[FW-2:0];
        in_sign = in_data[DW-1];
        in_up   = 1'b0;
        case (in_mode)
            2'd0:    in_up = in_half & (in_tail | in_int[0]);
            2'd1:    in_up = in_sign & (in_half | in_tail);
            2'd2:    in_up = 1'b0;
            default: in_up = in_half & (in_tail | ~in_sign);
        endcase
    end

    // Handshake: each stage loads when empty or when its contents leave this cycle.
    always_comb begin
        s2_load  = ~out_valid | out_ready;
        s1_adv   = s1_valid & s2_load;
        in_ready = ~s1_valid | s1_adv;
        in_fire  = in_valid & in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 payload is qualified by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_int     <= in_int;
            s1_up      <= in_up;
            s1_inexact <= in_half | in_tail;
        end
    end

`ifdef ROUND_PIPE_SAT_EN
    logic res_ovf;

    always_comb begin
        res_ovf  = s1_up & (s1_int == INT_MAX);
        res_data = res_ovf ? INT_MAX : (s1_int + OW'(s1_up));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sat <= 1'b0;
        end else if (s2_load && s1_valid) begin
            out_sat <= res_ovf;
        end
    end
`else
    // INT_MAX + 1 naturally wraps to the most negative value.
    always_comb begin
        res_data = s1_int + OW'(s1_up);
    end

    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= res_data;
                out_inexact <= s1_inexact;
            end
        end
    end

endmodule

// File: tb/tb_round_pipe.sv
// Directed bench for round_pipe (DW=16, FW=8): rounding modes, latency, back-pressure, async reset.
module tb_round_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_inexact;
    logic        out_sat;

    int errors = 0;
    int checks = 0;

    round_pipe #(.DW(16), .FW(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_inexact(out_inexact),
        .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat for one cycle, then expect it two edges after transfer.
    task automatic beat(input string tag, input logic [15:0] d, input logic [1:0] m,
                        input logic [7:0] ed, input logic ei, input logic es);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_mode = m;
        @(negedge clk);
        chk({tag, "_rdy"}, 16'(in_ready), 16'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_vld"}, 16'(out_valid), 16'(1'b1));
        chk({tag, "_data"}, 16'(out_data), 16'(ed));
        chk({tag, "_inx"}, 16'(out_inexact), 16'(ei));
        chk({tag, "_sat"}, 16'(out_sat), 16'(es));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_vld", 16'(out_valid), 16'(1'b0));
        chk("rst_data", 16'(out_data), 16'h0);
        chk("rst_inx", 16'(out_inexact), 16'(1'b0));
        chk("rst_sat", 16'(out_sat), 16'(1'b0));
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 16'(in_ready), 16'(1'b1));

        // Back-to-back nearest-even, exact two-cycle latency
        @(posedge clk); #1; in_valid = 1'b1; in_data = 16'h0280; in_mode = 2'd0;
        @(negedge clk); chk("b2b_c0_vld", 16'(out_valid), 16'(1'b0));
        @(posedge clk); #1; in_data = 16'h0380;
        @(negedge clk); chk("b2b_c1_vld", 16'(out_valid), 16'(1'b0));
        @(posedge clk); #1; in_data = 16'hFD80;
        @(negedge clk);
        chk("b2b_c2_vld", 16'(out_valid), 16'(1'b1));
        chk("b2b_c2_data", 16'(out_data), 16'h02);
        chk("b2b_c2_inx", 16'(out_inexact), 16'(1'b1));
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_c3_vld", 16'(out_valid), 16'(1'b1));
        chk("b2b_c3_data", 16'(out_data), 16'h04);
        chk("b2b_c3_inx", 16'(out_inexact), 16'(1'b1));
        @(negedge clk);
        chk("b2b_c4_vld", 16'(out_valid), 16'(1'b1));
        chk("b2b_c4_data", 16'(out_data), 16'hFE);
        chk("b2b_c4_inx", 16'(out_inexact), 16'(1'b1));
        @(negedge clk);
        chk("b2b_c5_vld", 16'(out_valid), 16'(1'b0));

        // Mode coverage and boundary values
        beat("fd80_m1", 16'hFD80, 2'd1, 8'hFE, 1'b1, 1'b0);
        beat("fd80_m2", 16'hFD80, 2'd2, 8'hFD, 1'b1, 1'b0);
        beat("fd80_m3", 16'hFD80, 2'd3, 8'hFD, 1'b1, 1'b0);
        beat("fd40_m1", 16'hFD40, 2'd1, 8'hFE, 1'b1, 1'b0);
        beat("0500_m0", 16'h0500, 2'd0, 8'h05, 1'b0, 1'b0);
        beat("0500_m1", 16'h0500, 2'd1, 8'h05, 1'b0, 1'b0);
        beat("0500_m2", 16'h0500, 2'd2, 8'h05, 1'b0, 1'b0);
        beat("0500_m3", 16'h0500, 2'd3, 8'h05, 1'b0, 1'b0);
        beat("02c0_m1", 16'h02C0, 2'd1, 8'h02, 1'b1, 1'b0);
        beat("0280_m3", 16'h0280, 2'd3, 8'h03, 1'b1, 1'b0);
        beat("02c0_m0", 16'h02C0, 2'd0, 8'h03, 1'b1, 1'b0);
        beat("fdc0_m2", 16'hFDC0, 2'd2, 8'hFD, 1'b1, 1'b0);
        beat("7f80_m1", 16'h7F80, 2'd1, 8'h7F, 1'b1, 1'b0);
`ifdef ROUND_PIPE_SAT_EN
        beat("7fc0_m0", 16'h7FC0, 2'd0, 8'h7F, 1'b1, 1'b1);
`else
        beat("7fc0_m0", 16'h7FC0, 2'd0, 8'h80, 1'b1, 1'b0);
`endif
        @(negedge clk);
        chk("idle_vld", 16'(out_valid), 16'(1'b0));

        // Back-pressure: out_ready low for 4 cycles while offering 3 beats
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0100; in_mode = 2'd2;
        @(negedge clk); chk("bp_c0_rdy", 16'(in_ready), 16'(1'b1));
        @(posedge clk); #1; in_data = 16'h0200;
        @(negedge clk); chk("bp_c1_rdy", 16'(in_ready), 16'(1'b1));
        @(posedge clk); #1; in_data = 16'h0300;
        @(negedge clk);
        chk("bp_c2_rdy", 16'(in_ready), 16'(1'b0));
        chk("bp_c2_vld", 16'(out_valid), 16'(1'b1));
        chk("bp_c2_data", 16'(out_data), 16'h01);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_c3_rdy", 16'(in_ready), 16'(1'b0));
        chk("bp_c3_data", 16'(out_data), 16'h01);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_c4_rdy", 16'(in_ready), 16'(1'b1));
        chk("bp_c4_vld", 16'(out_valid), 16'(1'b1));
        chk("bp_c4_data", 16'(out_data), 16'h01);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_c5_vld", 16'(out_valid), 16'(1'b1));
        chk("bp_c5_data", 16'(out_data), 16'h02);
        @(negedge clk);
        chk("bp_c6_vld", 16'(out_valid), 16'(1'b1));
        chk("bp_c6_data", 16'(out_data), 16'h03);
        @(negedge clk);
        chk("bp_c7_vld", 16'(out_valid), 16'(1'b0));

        // Async reset with two beats in flight
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0100; in_mode = 2'd2;
        @(posedge clk); #1; in_data = 16'h0200;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_vld", 16'(out_valid), 16'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("ar_async_vld", 16'(out_valid), 16'(1'b0));
        chk("ar_async_data", 16'(out_data), 16'h0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ar_post_rdy", 16'(in_ready), 16'(1'b1));
        for (int i = 0; i < 4; i++) begin
            chk("ar_no_stale", 16'(out_valid), 16'(1'b0));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
